// File: rtl/mdio_multi_master_if.sv
// Command/response port of the multi-channel MDIO engine.
// The master side (register block) offers commands and takes responses;
// the slave side is the MDIO engine itself.
interface mdio_multi_master_if #(
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0]    cmd_mask;
  logic                   cmd_c45;
  logic [1:0]             cmd_opcode;
  logic [4:0]             cmd_phy_addr;
  logic [4:0]             cmd_reg_addr;
  logic [15:0]            cmd_data;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [16*CHANNELS-1:0] rsp_rdata;
  logic [CHANNELS-1:0]    rsp_err;
  logic                   rsp_valid;
  logic                   rsp_ready;

  modport master (
    output cmd_mask, cmd_c45, cmd_opcode, cmd_phy_addr, cmd_reg_addr, cmd_data, cmd_valid,
    input  cmd_ready,
    input  rsp_rdata, rsp_err, rsp_valid,
    output rsp_ready
  );

  modport slave (
    input  cmd_mask, cmd_c45, cmd_opcode, cmd_phy_addr, cmd_reg_addr, cmd_data, cmd_valid,
    output cmd_ready,
    output rsp_rdata, rsp_err, rsp_valid,
    input  rsp_ready
  );
endinterface

// File: rtl/mdio_multi_master.sv
// Multi-channel MDIO engine: one command drives a Clause 22 or Clause 45
// frame onto every channel selected by cmd_mask in lock-step. Reads sample
// all selected channels in parallel and report per-channel data and a
// missing-turnaround-ack flag.
module mdio_multi_master #(
  parameter int CHANNELS       = 2,
  parameter int PRESCALE_WIDTH = 8,
  parameter bit CLAUSE45_EN    = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  mdio_multi_master_if.slave        bus,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      no_preamble,
  output logic                      busy,
  output logic [CHANNELS-1:0]       mdc_o,
  input  logic [CHANNELS-1:0]       mdio_i,
  output logic [CHANNELS-1:0]       mdio_o,
  output logic [CHANNELS-1:0]       mdio_t
);

  typedef enum logic [1:0] {IDLE, PRE, FRAME, RESP} state_t;

  state_t                        state;
  logic [CHANNELS-1:0]           mask_q;
  logic [PRESCALE_WIDTH-1:0]     half_q;     // MDC half period latched at accept
  logic [PRESCALE_WIDTH-1:0]     div_cnt;
  logic                          mdc_hi;     // current bit is in its high phase
  logic                          rd_q;
  logic [4:0]                    bit_idx;    // frame bit index, 31 sent first
  logic [31:0]                   frame_q;
  logic [CHANNELS-1:0][15:0]     rd_sh;
  logic [CHANNELS-1:0]           err_sh;

  // Decode of the offered command; Clause 45 is only honoured when enabled.
  logic                      c45_eff;
  logic                      cmd_is_read;
  logic [31:0]               cmd_frame;
  logic [PRESCALE_WIDTH-1:0] half_cyc;
  logic                      half_done;
  logic [4:0]                nxt_idx;

  assign c45_eff     = bus.cmd_c45 & CLAUSE45_EN;
  assign cmd_is_read = c45_eff ? bus.cmd_opcode[1] : (bus.cmd_opcode == 2'b10);
  assign cmd_frame   = {(c45_eff ? 2'b00 : 2'b01), bus.cmd_opcode, bus.cmd_phy_addr,
                        bus.cmd_reg_addr, 2'b10, (cmd_is_read ? 16'h0000 : bus.cmd_data)};
  assign half_cyc    = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
  assign half_done   = (div_cnt == half_q - PRESCALE_WIDTH'(1));
  assign nxt_idx     = bit_idx - 5'd1;

  // Frame sequencer: command accept, MDC generation, shifting and sampling.
  // NOTE: every register here uses <= so all state advances together on the
  // clock edge; the read shift registers are reset too, so an aborted frame
  // never leaks stale data into the next response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      mask_q        <= '0;
      half_q        <= PRESCALE_WIDTH'(1);
      div_cnt       <= '0;
      mdc_hi        <= 1'b0;
      rd_q          <= 1'b0;
      bit_idx       <= '0;
      frame_q       <= '0;
      rd_sh         <= '0;
      err_sh        <= '0;
      busy          <= 1'b0;
      mdc_o         <= '0;
      mdio_o        <= '1;
      mdio_t        <= '1;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            mask_q  <= bus.cmd_mask;
            half_q  <= half_cyc;
            rd_q    <= cmd_is_read;
            frame_q <= cmd_frame;
            bit_idx <= 5'd31;
            div_cnt <= '0;
            mdc_hi  <= 1'b0;
            rd_sh   <= '0;
            err_sh  <= '0;
            if (bus.cmd_mask == '0) begin
              // Nothing to clock out: a read answers at once with zeros.
              if (cmd_is_read) begin
                state         <= RESP;
                bus.cmd_ready <= 1'b0;
                bus.rsp_valid <= 1'b1;
                bus.rsp_rdata <= '0;
                bus.rsp_err   <= '0;
              end
            end else begin
              state         <= no_preamble ? FRAME : PRE;
              busy          <= 1'b1;
              bus.cmd_ready <= 1'b0;
              mdio_t        <= ~bus.cmd_mask;
              mdio_o        <= (no_preamble ? {CHANNELS{cmd_frame[31]}} : '1) | ~bus.cmd_mask;
            end
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end

        PRE, FRAME: begin
          if (!half_done) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!mdc_hi) begin
              // Rising MDC: PHY data is sampled here.
              mdc_hi <= 1'b1;
              mdc_o  <= mask_q;
              if (state == FRAME && rd_q) begin
                if (bit_idx == 5'd16) err_sh <= mdio_i & mask_q;
                if (bit_idx < 5'd16) begin
                  for (int i = 0; i < CHANNELS; i++)
                    rd_sh[i] <= {rd_sh[i][14:0], mdio_i[i] & mask_q[i]};
                end
              end
            end else begin
              // Falling MDC: present the next bit or close the frame.
              mdc_hi <= 1'b0;
              mdc_o  <= '0;
              if (bit_idx != 5'd0) begin
                bit_idx <= nxt_idx;
                mdio_o  <= ((state == FRAME) ? {CHANNELS{frame_q[nxt_idx]}} : '1) | ~mask_q;
                if (state == FRAME && rd_q && nxt_idx == 5'd17) mdio_t <= '1;
              end else if (state == PRE) begin
                state   <= FRAME;
                bit_idx <= 5'd31;
                mdio_o  <= {CHANNELS{frame_q[31]}} | ~mask_q;
              end else begin
                busy   <= 1'b0;
                mdio_t <= '1;
                mdio_o <= '1;
                if (rd_q) begin
                  state         <= RESP;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_rdata <= rd_sh;
                  bus.rsp_err   <= err_sh;
                end else begin
                  state         <= IDLE;
                  bus.cmd_ready <= 1'b1;
                end
              end
            end
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_multi_master.sv
// Directed bench for mdio_multi_master with a per-channel PHY model, a pin
// monitor and a response scoreboard.
module tb_mdio_multi_master;
  localparam int CH = 2;
  localparam int PW = 8;

  typedef struct packed {
    logic [16*CH-1:0] rdata;
    logic [CH-1:0]    err;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [PW-1:0] prescale;
  logic          no_preamble;
  logic          busy;
  logic [CH-1:0] mdc_o, mdio_i, mdio_o, mdio_t;

  mdio_multi_master_if #(.CHANNELS(CH)) bus ();

  mdio_multi_master #(.CHANNELS(CH), .PRESCALE_WIDTH(PW), .CLAUSE45_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .prescale(prescale), .no_preamble(no_preamble),
    .busy(busy), .mdc_o(mdc_o), .mdio_i(mdio_i), .mdio_o(mdio_o), .mdio_t(mdio_t)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];

  // PHY model state, set by the stimulus
  logic [15:0]   cur_word[CH];
  logic [CH-1:0] present = '1;
  bit            cur_nopre = 1'b0;
  bit            cur_read  = 1'b0;
  logic [4:0]    c45_addr[CH] = '{default: 5'd0};
  int            off;

  // Monitor state
  int            cnt[CH] = '{default: 0};
  logic [63:0]   wire_sh[CH] = '{default: 64'd0};
  logic [63:0]   t_sh[CH] = '{default: 64'd0};
  logic [CH-1:0] act = '0, prev_mdc = '0;
  int            busy_cyc = 0;
  logic          prev_busy = 1'b0;
  int            last_cnt[CH] = '{default: 0};
  logic [63:0]   last_wire[CH] = '{default: 64'd0};
  logic [63:0]   last_t[CH] = '{default: 64'd0};
  logic [CH-1:0] last_act = '0;
  int            last_busy_cyc = 0;

  assign off = cur_nopre ? 0 : 32;

  // PHY model: acks TA with 0 and returns its word during the data bits
  always_comb begin
    mdio_i = '1;
    for (int i = 0; i < CH; i++) begin
      if (cur_read && present[i]) begin
        if (cnt[i] - off == 15) mdio_i[i] = 1'b0;
        else if (cnt[i] - off >= 16 && cnt[i] - off <= 31) mdio_i[i] = cur_word[i][31 - (cnt[i] - off)];
      end
    end
  end

  // Pin monitor: captures wire bits at each MDC high phase, snapshots at frame end
  always @(posedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (mdc_o[i] && !prev_mdc[i]) begin
        cnt[i]     = cnt[i] + 1;
        wire_sh[i] = {wire_sh[i][62:0], mdio_o[i]};
        t_sh[i]    = {t_sh[i][62:0], mdio_t[i]};
      end
      if (mdc_o[i] || !mdio_t[i]) act[i] = 1'b1;
    end
    prev_mdc = mdc_o;
    if (busy === 1'b1) busy_cyc = busy_cyc + 1;
    if (prev_busy && busy === 1'b0) begin
      for (int i = 0; i < CH; i++) begin
        last_cnt[i]  = cnt[i];
        last_wire[i] = wire_sh[i];
        last_t[i]    = t_sh[i];
        cnt[i]       = 0;
        wire_sh[i]   = '0;
        t_sh[i]      = '0;
      end
      last_act      = act;
      act           = '0;
      last_busy_cyc = busy_cyc;
      busy_cyc      = 0;
    end
    prev_busy = (busy === 1'b1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] reg_val(input int ch, input logic [4:0] a);
    case (a)
      5'd1:    return (ch == 1) ? 16'h796D : 16'hA5C3;
      5'd7:    return 16'h7070 + 16'(ch);
      default: return {3'b000, a, 8'(ch)};
    endcase
  endfunction

  task automatic send(input logic [CH-1:0] m, input bit c45, input logic [1:0] op,
                      input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d,
                      input logic [PW-1:0] p, input bit np);
    bit   rd;
    rsp_t e;
    int   n;
    rd = c45 ? op[1] : (op == 2'b10);
    e  = '0;
    @(negedge clk);
    cur_nopre = np;
    cur_read  = rd;
    for (int i = 0; i < CH; i++) begin
      cur_word[i] = reg_val(i, c45 ? c45_addr[i] : ra);
      e.rdata[16*i +: 16] = !m[i] ? 16'h0000 : (present[i] ? cur_word[i] : 16'hFFFF);
      e.err[i] = m[i] & ~present[i];
      if (m[i] && c45 && op == 2'b00) c45_addr[i] = d[4:0];
    end
    if (rd) exp_q.push_back(e);
    bus.cmd_mask = m; bus.cmd_c45 = c45; bus.cmd_opcode = op;
    bus.cmd_phy_addr = phy; bus.cmd_reg_addr = ra; bus.cmd_data = d;
    prescale = p; no_preamble = np; bus.cmd_valid = 1'b1;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) check("cmd_accept_timeout", 0, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 20000) begin @(negedge clk); n++; end
    if (n >= 20000) check({tag, "_busy_timeout"}, 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_rsp(input string tag, input int hold);
    rsp_t            e;
    int              n = 0;
    logic [16*CH-1:0] r0;
    logic [CH-1:0]   e0;
    bit              stable = 1'b1;
    while (bus.rsp_valid !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    check({tag, "_rsp_valid"}, bus.rsp_valid, 1);
    if (bus.rsp_valid === 1'b1) begin
      check({tag, "_rsp_expected"}, exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({tag, "_rdata"}, bus.rsp_rdata, e.rdata);
        check({tag, "_err"}, bus.rsp_err, e.err);
      end
      r0 = bus.rsp_rdata;
      e0 = bus.rsp_err;
      repeat (hold) begin
        @(negedge clk);
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== r0 || bus.rsp_err !== e0 || bus.cmd_ready !== 1'b0)
          stable = 1'b0;
      end
      if (hold > 0) check({tag, "_hold_stable"}, stable, 1);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check({tag, "_rsp_cleared"}, bus.rsp_valid, 0);
      check({tag, "_ready_after_rsp"}, bus.cmd_ready, 1);
    end
  endtask

  initial begin
    int n;
    bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0; bus.cmd_mask = '0; bus.cmd_c45 = 1'b0;
    bus.cmd_opcode = '0; bus.cmd_phy_addr = '0; bus.cmd_reg_addr = '0; bus.cmd_data = '0;
    prescale = 8'd1; no_preamble = 1'b0;
    for (int i = 0; i < CH; i++) cur_word[i] = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_mdc", mdc_o, 2'b00);
    check("rst_mdio_o", mdio_o, 2'b11);
    check("rst_mdio_t", mdio_t, 2'b11);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rdata", bus.rsp_rdata, 0);
    check("rst_err", bus.rsp_err, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", bus.cmd_ready, 1);

    // Broadcast C22 write with preamble, P=2; mid-frame setting changes ignored
    send(2'b11, 1'b0, 2'b01, 5'd3, 5'd0, 16'h2100, 8'd2, 1'b0);
    check("t1_busy_next", busy, 1);
    prescale = 8'd7; no_preamble = 1'b1;
    wait_idle("t1");
    check("t1_busy_cycles", last_busy_cyc, 256);
    check("t1_mdc_ch0", last_cnt[0], 64);
    check("t1_mdc_ch1", last_cnt[1], 64);
    check("t1_wire_ch0", last_wire[0], 64'hFFFF_FFFF_5182_2100);
    check("t1_wire_ch1", last_wire[1], 64'hFFFF_FFFF_5182_2100);
    check("t1_no_rsp", bus.rsp_valid, 0);
    check("t1_ready", bus.cmd_ready, 1);

    // Masked C22 read on ch1 only, P=1, no preamble
    send(2'b10, 1'b0, 2'b10, 5'd2, 5'd1, 16'hFFFF, 8'd1, 1'b1);
    wait_idle("t2");
    check("t2_busy_cycles", last_busy_cyc, 64);
    check("t2_ch0_idle", last_act[0], 0);
    check("t2_ch1_bits", last_cnt[1], 32);
    check("t2_ch1_tristate", last_t[1][31:0], 32'h0003_FFFF);
    check("t2_ch1_header", last_wire[1][31:18], {2'b01, 2'b10, 5'd2, 5'd1});
    wait_rsp("t2", 0);

    // ch0 PHY absent, P=3 with preamble, response held off for 10 cycles
    present = 2'b10;
    send(2'b11, 1'b0, 2'b10, 5'd4, 5'd1, 16'h0000, 8'd3, 1'b0);
    wait_idle("t3");
    check("t3_busy_cycles", last_busy_cyc, 384);
    wait_rsp("t3", 10);
    present = 2'b11;

    // Clause 45 address frame then read of the addressed register
    send(2'b11, 1'b1, 2'b00, 5'd5, 5'd1, 16'h0007, 8'd2, 1'b1);
    wait_idle("t4a");
    check("t4_busy_cycles", last_busy_cyc, 128);
    check("t4_wire_ch0", last_wire[0][31:0], {2'b00, 2'b00, 5'd5, 5'd1, 2'b10, 16'h0007});
    check("t4_no_rsp", bus.rsp_valid, 0);
    send(2'b11, 1'b1, 2'b10, 5'd5, 5'd1, 16'h0000, 8'd1, 1'b1);
    wait_idle("t4b");
    check("t4_read_st", last_wire[1][31:28], 4'b0010);
    wait_rsp("t4", 0);

    // Empty mask read: immediate response, no pin activity
    send(2'b00, 1'b0, 2'b10, 5'd1, 5'd1, 16'h0000, 8'd1, 1'b0);
    check("t5_rsp_next", bus.rsp_valid, 1);
    check("t5_busy", busy, 0);
    wait_rsp("t5", 0);
    check("t5_pins_idle", act, 0);

    // Reset in the middle of a read, then a fresh write
    send(2'b11, 1'b0, 2'b10, 5'd1, 5'd1, 16'h0000, 8'd2, 1'b0);
    n = 0;
    while (cnt[0] < 43 && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) check("t6_bit20_timeout", 0, 1);
    rst = 1'b1;
    #1;
    check("t6_abort_t", mdio_t, 2'b11);
    check("t6_abort_mdc", mdc_o, 2'b00);
    check("t6_abort_busy", busy, 0);
    check("t6_abort_rsp", bus.rsp_valid, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_ready", bus.cmd_ready, 1);
    send(2'b01, 1'b0, 2'b01, 5'd7, 5'd3, 16'h1234, 8'd1, 1'b1);
    wait_idle("t6");
    check("t6_busy_cycles", last_busy_cyc, 64);
    check("t6_wire_ch0", last_wire[0][31:0], {2'b01, 2'b01, 5'd7, 5'd3, 2'b10, 16'h1234});
    check("t6_ch1_idle", last_act[1], 0);
    check("t6_no_rsp", bus.rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
